zoom_line_ctrl: RTL and testbench

Ping-pong line-buffer controller for the `zoom_ram` simple dual-port RAM: 2048×16, registered address, 1-cycle read latency, no output register. It writes one incoming video line into one 1024-word half of the RAM while the other half is read out with nearest-neighbour horizontal scaling. It sits between the pixel input stream and the zoom output stage, and both RAM ports run on `wr_clk`.

---
 rtl/zoom_line_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_zoom_line_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_line_ctrl.sv
// zoom_line_ctrl: ping-pong line-buffer controller for a 2048x16 simple dual-port RAM
// (registered address, 1-cycle read latency). One bank is filled with an incoming line
// while the other is read out with nearest-neighbour horizontal scaling.
//
// Ports:
//   wr_clk, tb_wr_rst            clock and asynchronous active-high reset
//   in_valid/in_data/in_eol      input pixel stream, in_ready back-pressure
//   cfg_step, cfg_out_len        8.8 source step per output pixel, output pixels per line
//   ram_wr_en/addr/data          RAM write port (combinational from the accepting cycle)
//   ram_rd_addr, ram_rd_data     RAM read port
//   out_valid/out_data/out_eol   scaled output stream, out_ready back-pressure
//   overflow                     sticky: an input line was longer than one bank
module zoom_line_ctrl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC       = 8
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_eol,
  output logic                  in_ready,
  input  logic [15:0]           cfg_step,
  input  logic [ADDR_WIDTH-1:0] cfg_out_len,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_eol,
  input  logic                  out_ready,
  output logic                  overflow
);

  localparam int unsigned BankAw    = ADDR_WIDTH - 1;
  localparam int unsigned BankWords = 1 << BankAw;
  localparam int unsigned AccW      = 19;

  localparam logic [1:0] BkEmpty   = 2'd0;
  localparam logic [1:0] BkFilling = 2'd1;
  localparam logic [1:0] BkFull    = 2'd2;
  localparam logic [1:0] BkReading = 2'd3;

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic [1:0][1:0]            bank_st_q, bank_st_d;
  logic [1:0][ADDR_WIDTH-1:0] len_q, len_d;
  logic                       wb_q, wb_d, rb_q, rb_d;
  logic [ADDR_WIDTH-1:0]      wcnt_q, wcnt_d;
  logic                       overflow_q, overflow_d;
  logic                       rd_st_q, rd_st_d;
  logic                       valid_q, valid_d;
  logic [AccW-1:0]            acc_q, acc_d, acc_nxt;
  logic [15:0]                stp_q, stp_d;
  logic [ADDR_WIDTH-1:0]      olen_q, olen_d;
  logic [ADDR_WIDTH-1:0]      ocnt_q, ocnt_d;
  logic [AccW:0]              acc_sum;
  logic [ADDR_WIDTH-1:0]      rd_len;
  logic [BankAw-1:0]          idx_cur, idx_nxt;
  logic                       wr_fire, wr_full, rd_fire;

  // Clamp the integer part of the accumulator to the last stored pixel of the line.
  function automatic logic [BankAw-1:0] src_idx(input logic [AccW-1:0] acc,
                                                input logic [ADDR_WIDTH-1:0] len);
    logic [AccW-1:0]       src;
    logic [ADDR_WIDTH-1:0] last;
    src  = acc >> FRAC;
    last = len - ADDR_WIDTH'(1);
    if (len == '0) begin
      src_idx = '0;
    end else if (src >= AccW'(len)) begin
      src_idx = last[BankAw-1:0];
    end else begin
      src_idx = src[BankAw-1:0];
    end
  endfunction

  // Write side
  assign in_ready    = !tb_wr_rst &&
                       (bank_st_q[wb_q] == BkEmpty || bank_st_q[wb_q] == BkFilling);
  assign wr_fire     = in_valid && in_ready;
  assign wr_full     = (wcnt_q == ADDR_WIDTH'(BankWords));
  assign ram_wr_en   = wr_fire && !wr_full;
  assign ram_wr_addr = {wb_q, wcnt_q[BankAw-1:0]};
  assign ram_wr_data = in_data;
  assign overflow    = overflow_q;

  // Read side
  assign acc_sum     = {1'b0, acc_q} + (AccW + 1)'(stp_q);
  assign acc_nxt     = acc_sum[AccW] ? '1 : acc_sum[AccW-1:0];
  assign rd_len      = len_q[rb_q];
  assign idx_cur     = src_idx(acc_q, rd_len);
  assign idx_nxt     = src_idx(acc_nxt, rd_len);
  assign out_valid   = valid_q;
  assign rd_fire     = valid_q && out_ready;
  assign out_eol     = valid_q && (ocnt_q == olen_q - ADDR_WIDTH'(1));
  assign out_data    = ram_rd_data;
  // Present the following address on the handshake edge so the next pixel is back-to-back.
  assign ram_rd_addr = {rb_q, rd_fire ? idx_nxt : idx_cur};

  always_comb begin
    bank_st_d  = bank_st_q;
    len_d      = len_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    wcnt_d     = wcnt_q;
    overflow_d = overflow_q;
    rd_st_d    = rd_st_q;
    valid_d    = valid_q;
    acc_d      = acc_q;
    stp_d      = stp_q;
    olen_d     = olen_q;
    ocnt_d     = ocnt_q;

    if (wr_fire) begin
      if (wr_full) begin
        overflow_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + ADDR_WIDTH'(1);
      end
      bank_st_d[wb_q] = BkFilling;
      if (in_eol) begin
        len_d[wb_q]     = wr_full ? wcnt_q : wcnt_q + ADDR_WIDTH'(1);
        bank_st_d[wb_q] = BkFull;
        wb_d            = ~wb_q;
        wcnt_d          = '0;
      end
    end

    // The write side only touches EMPTY/FILLING banks and the read side only FULL/READING
    // ones, so both updates may land in the same cycle without conflict.
    case (rd_st_q)
      StIdle: begin
        if (bank_st_q[rb_q] == BkFull) begin
          rd_st_d         = StRun;
          stp_d           = cfg_step;
          olen_d          = cfg_out_len;
          acc_d           = '0;
          ocnt_d          = '0;
          bank_st_d[rb_q] = BkReading;
        end
      end
      default: begin
        if (!valid_q) begin
          // First RUN cycle: address 0 is on the RAM, data arrives next cycle.
          if (olen_q == '0) begin
            bank_st_d[rb_q] = BkEmpty;
            rb_d            = ~rb_q;
            rd_st_d         = StIdle;
          end else begin
            valid_d = 1'b1;
          end
        end else if (rd_fire) begin
          acc_d  = acc_nxt;
          ocnt_d = ocnt_q + ADDR_WIDTH'(1);
          if (out_eol) begin
            bank_st_d[rb_q] = BkEmpty;
            rb_d            = ~rb_q;
            rd_st_d         = StIdle;
            valid_d         = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      bank_st_q  <= '0;
      len_q      <= '0;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      wcnt_q     <= '0;
      overflow_q <= 1'b0;
      rd_st_q    <= StIdle;
      valid_q    <= 1'b0;
      acc_q      <= '0;
      stp_q      <= '0;
      olen_q     <= '0;
      ocnt_q     <= '0;
    end else begin
      bank_st_q  <= bank_st_d;
      len_q      <= len_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      wcnt_q     <= wcnt_d;
      overflow_q <= overflow_d;
      rd_st_q    <= rd_st_d;
      valid_q    <= valid_d;
      acc_q      <= acc_d;
      stp_q      <= stp_d;
      olen_q     <= olen_d;
      ocnt_q     <= ocnt_d;
    end
  end

endmodule

// File: tb/tb_zoom_line_ctrl.sv
// Directed bench for zoom_line_ctrl with a behavioural zoom_ram model
// (registered read address, 1-cycle latency, no output register).
module tb_zoom_line_ctrl;

  logic        wr_clk;
  logic        tb_wr_rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_eol;
  logic        in_ready;
  logic [15:0] cfg_step;
  logic [10:0] cfg_out_len;
  logic        ram_wr_en;
  logic [10:0] ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic [10:0] ram_rd_addr;
  logic [15:0] ram_rd_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_eol;
  logic        out_ready;
  logic        overflow;

  zoom_line_ctrl #(
    .ADDR_WIDTH(11),
    .DATA_WIDTH(16),
    .FRAC      (8)
  ) dut (
    .wr_clk     (wr_clk),
    .tb_wr_rst  (tb_wr_rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_eol     (in_eol),
    .in_ready   (in_ready),
    .cfg_step   (cfg_step),
    .cfg_out_len(cfg_out_len),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_eol    (out_eol),
    .out_ready  (out_ready),
    .overflow   (overflow)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // RAM model
  logic [15:0] mem [2048];
  logic [10:0] rd_addr_q;
  always @(posedge wr_clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    rd_addr_q <= ram_rd_addr;
  end
  assign ram_rd_data = mem[rd_addr_q];

  // Output capture: a transfer happens on the posedge following a negedge with valid&ready.
  logic [15:0] oq[$];
  logic        eq[$];
  always @(negedge wr_clk) begin
    if (out_valid && out_ready) begin
      oq.push_back(out_data);
      eq.push_back(out_eol);
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int timeouts = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic send_line(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      int w;
      bit ok;
      w  = 0;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = base + 16'(i);
      in_eol   = (i == n - 1);
      while (!ok && w < 5000) begin
        @(negedge wr_clk);
        ok = in_ready;
        tick();
        w++;
      end
      if (!ok) begin
        timeouts++;
        break;
      end
    end
    in_valid = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    int c;
    c = 0;
    while (oq.size() < n && c < 5000) begin
      tick();
      c++;
    end
    chk(tag, oq.size(), n);
  endtask

  initial begin
    tb_wr_rst   = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_eol      = 1'b0;
    cfg_step    = 16'h0100;
    cfg_out_len = 11'd16;
    out_ready   = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_eol", out_eol, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rd_addr", ram_rd_addr, 0);
    tb_wr_rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Combinational write port
    in_valid = 1'b1;
    in_data  = 16'h00ab;
    #1;
    chk("wr_en_comb", ram_wr_en, 1);
    chk("wr_addr_comb", ram_wr_addr, 11'h000);
    chk("wr_data_comb", ram_wr_data, 16'h00ab);
    in_valid = 1'b0;
    #1;

    // Unity scale, plus latency from in_eol to first out_valid
    oq.delete(); eq.delete();
    send_line(16, 16'h0000);
    chk("t1_valid_e0", out_valid, 0);
    tick();
    chk("t1_valid_e1", out_valid, 0);
    tick();
    chk("t1_valid_e2", out_valid, 1);
    wait_out(16, "t1_count");
    for (int i = 0; i < 16; i++) begin
      chk("t1_data", oq[i], 16'(i));
      chk("t1_eol", eq[i], (i == 15));
    end
    tick();

    // 2x upscale
    oq.delete(); eq.delete();
    cfg_step = 16'h0080; cfg_out_len = 11'd16;
    send_line(8, 16'h0000);
    wait_out(16, "t2_count");
    for (int i = 0; i < 16; i++) chk("t2_data", oq[i], 16'(i / 2));
    chk("t2_eol", eq[15], 1);
    tick();

    // Downscale with clamp: source indices 0,3,6,9,9
    oq.delete(); eq.delete();
    cfg_step = 16'h0300; cfg_out_len = 11'd5;
    send_line(10, 16'd100);
    wait_out(5, "t3_count");
    chk("t3_d0", oq[0], 16'd100);
    chk("t3_d1", oq[1], 16'd103);
    chk("t3_d2", oq[2], 16'd106);
    chk("t3_d3", oq[3], 16'd109);
    chk("t3_d4", oq[4], 16'd109);
    chk("t3_eol", eq[4], 1);
    tick();

    // Back-pressure: two full banks stall input; third line waits, nothing lost
    oq.delete(); eq.delete();
    cfg_step = 16'h0100; cfg_out_len = 11'd64;
    out_ready = 1'b0;
    send_line(64, 16'h1000);
    send_line(64, 16'h2000);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_addr", ram_rd_addr, 11'h400);
    chk("bp_data", out_data, 16'h1000);
    repeat (2) tick();
    chk("bp_addr_hold", ram_rd_addr, 11'h400);
    chk("bp_data_hold", out_data, 16'h1000);
    fork
      send_line(64, 16'h3000);
      begin
        int c;
        c = 0;
        while (oq.size() < 192 && c < 3000) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
          c++;
        end
        out_ready = 1'b1;
      end
    join
    wait_out(192, "bp_count");
    for (int k = 0; k < 192; k++) begin
      chk("bp_data_seq", oq[k], 16'(((k / 64) + 1) * 16'h1000 + (k % 64)));
      chk("bp_eol_seq", eq[k], ((k % 64) == 63));
    end
    tick();

    // Overflow: 1030-pixel line, length clamps to 1024
    oq.delete(); eq.delete();
    cfg_step = 16'h0100; cfg_out_len = 11'd1026;
    send_line(1030, 16'h8000);
    chk("ovf_flag", overflow, 1);
    wait_out(1026, "ovf_count");
    chk("ovf_d0", oq[0], 16'h8000);
    chk("ovf_d1022", oq[1022], 16'h83fe);
    chk("ovf_d1023", oq[1023], 16'h83ff);
    chk("ovf_clamp1024", oq[1024], 16'h83ff);
    chk("ovf_clamp1025", oq[1025], 16'h83ff);
    chk("ovf_eol", eq[1025], 1);
    chk("ovf_sticky", overflow, 1);
    tick();

    // Async reset mid-output
    oq.delete(); eq.delete();
    cfg_step = 16'h0100; cfg_out_len = 11'd4;
    out_ready = 1'b0;
    send_line(4, 16'h7000);
    repeat (3) tick();
    chk("ar_valid_before", out_valid, 1);
    #2;
    tb_wr_rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_overflow", overflow, 0);
    chk("ar_rd_addr", ram_rd_addr, 0);
    repeat (2) tick();
    tb_wr_rst = 1'b0;
    #1;
    chk("ar_rel_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) tick();
    chk("ar_no_partial", oq.size(), 0);
    send_line(4, 16'h7100);
    wait_out(4, "ar_count");
    for (int i = 0; i < 4; i++) chk("ar_data", oq[i], 16'h7100 + 16'(i));
    chk("ar_eol", eq[3], 1);

    chk("send_timeouts", timeouts, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
